// File: rtl/decoder_rx_framer.sv
// Serial receive framer: start bit, 7 data bits LSB-first, optional even parity, stop bit.
// Completed words are offered on a valid/ready interface that feeds the decoder io_in bus.
module decoder_rx_framer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       rx_i,
    output logic [6:0] word_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       busy_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [6:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [6:0]    word_q, word_d;
    logic          valid_q, valid_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          deliver;
    logic          rxs;

    assign rxs = sync_q[1];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            word_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[0], rx_i};
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        word_d  = word_q;
        valid_d = valid_q;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        deliver = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                // Mid-point of the start bit: a high line here was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bit_d   = '0;
                        par_d   = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[6:1]};
                    par_d   = par_q ^ rxs;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd6) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = par_q ^ rxs;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end else begin
                        state_d = S_IDLE;
                        if ((PARITY_EN != 0) && par_q) begin
                            perr_d = 1'b1;
                        end else begin
                            deliver = 1'b1;
                        end
                    end
                end
            end
            S_BREAK: begin
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        // A word completing while the previous one is still held (and not being taken) is dropped.
        if (deliver) begin
            if (!valid_q || ready_i) begin
                word_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign word_o       = word_q;
    assign valid_o      = valid_q;
    assign busy_o       = (state_q != S_IDLE);
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_decoder_rx_framer.sv
// Directed bench for decoder_rx_framer: drives serial frames and checks timing, data and error pulses.
module tb_decoder_rx_framer;

    localparam int N = 16;
    localparam int LAT = 155;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic       rx_i = 1'b1;
    logic       ready_i = 1'b0;
    logic [6:0] word_o;
    logic       valid_o;
    logic       busy_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       overrun_o;

    decoder_rx_framer #(
        .CLKS_PER_BIT(N),
        .PARITY_EN   (1)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (srst),
        .rx_i        (rx_i),
        .word_o      (word_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .parity_err_o(parity_err_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor; cleared whenever the stimulus bumps epoch.
    int epoch = 0;
    int last_epoch = 0;
    int valid_cnt, valid_cyc, valid_word;
    int par_cnt, par_cyc, frm_cnt, frm_cyc, ovr_cnt, ovr_cyc;
    int busy_cnt, fall_cnt, fall_cyc;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        if (epoch != last_epoch) begin
            last_epoch = epoch;
            valid_cnt = 0; valid_cyc = -1; valid_word = -1;
            par_cnt = 0; par_cyc = -1; frm_cnt = 0; frm_cyc = -1;
            ovr_cnt = 0; ovr_cyc = -1; busy_cnt = 0; fall_cnt = 0; fall_cyc = -1;
        end
        if (valid_o) begin
            if (valid_cnt == 0) begin
                valid_cyc  = cyc;
                valid_word = int'(word_o);
            end
            valid_cnt++;
        end
        if (parity_err_o) begin par_cnt++; par_cyc = cyc; end
        if (frame_err_o)  begin frm_cnt++; frm_cyc = cyc; end
        if (overrun_o)    begin ovr_cnt++; ovr_cyc = cyc; end
        if (busy_o) busy_cnt++;
        if (prev_busy && !busy_o) begin fall_cnt++; fall_cyc = cyc; end
        prev_busy = busy_o;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx_i = b;
        wait_cyc(N);
    endtask

    task automatic send_frame(input logic [6:0] d, input logic p, input logic stop, output int t0);
        t0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 7; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(stop);
        rx_i = 1'b1;
    endtask

    int k, k2, r;

    initial begin
        valid_cnt = 0; valid_cyc = -1; valid_word = -1;
        par_cnt = 0; par_cyc = -1; frm_cnt = 0; frm_cyc = -1;
        ovr_cnt = 0; ovr_cyc = -1; busy_cnt = 0; fall_cnt = 0; fall_cyc = -1;

        wait_cyc(3);
        srst = 1'b0;
        $display("reset: word=%0d valid=%0d busy=%0d", word_o, valid_o, busy_o);
        chk("rst_word", int'(word_o), 0);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_errs", int'({parity_err_o, frame_err_o, overrun_o}), 0);
        wait_cyc(5);

        // 0x42 clean frame, ready held high
        ready_i = 1'b1;
        epoch++;
        send_frame(7'h42, 1'b0, 1'b1, k);
        wait_cyc(20);
        $display("frame 0x42: valid at +%0d, word=0x%02h, valid cycles=%0d", valid_cyc - k, valid_word, valid_cnt);
        chk("t1_latency", valid_cyc - k, LAT);
        chk("t1_valid_cnt", valid_cnt, 1);
        chk("t1_word", valid_word, 'h42);
        chk("t1_errs", par_cnt + frm_cnt + ovr_cnt, 0);

        // 4-cycle low glitch
        epoch++;
        rx_i = 1'b0;
        wait_cyc(4);
        rx_i = 1'b1;
        wait_cyc(30);
        $display("glitch: busy cycles=%0d falls=%0d valid=%0d", busy_cnt, fall_cnt, valid_cnt);
        chk("t2_busy_cnt", busy_cnt, N / 2);
        chk("t2_busy_fall", fall_cnt, 1);
        chk("t2_quiet", valid_cnt + par_cnt + frm_cnt + ovr_cnt, 0);

        // 0x42 with bad parity
        epoch++;
        send_frame(7'h42, 1'b1, 1'b1, k);
        wait_cyc(20);
        $display("frame 0x42 bad parity: parity pulses=%0d at +%0d valid=%0d", par_cnt, par_cyc - k, valid_cnt);
        chk("t3_par_cnt", par_cnt, 1);
        chk("t3_par_time", par_cyc - k, LAT);
        chk("t3_no_valid", valid_cnt, 0);
        chk("t3_no_frm", frm_cnt + ovr_cnt, 0);

        // 0x7F with low stop bit, line held low
        epoch++;
        send_frame(7'h7F, 1'b1, 1'b0, k);
        rx_i = 1'b0;
        wait_cyc(40);
        r = cyc;
        rx_i = 1'b1;
        wait_cyc(40);
        $display("frame 0x7F break: frame pulses=%0d at +%0d busy fall +%0d after release", frm_cnt, frm_cyc - k, fall_cyc - r);
        chk("t4_frm_cnt", frm_cnt, 1);
        chk("t4_frm_time", frm_cyc - k, LAT);
        chk("t4_busy_release", fall_cyc - r, 3);
        chk("t4_one_frame", fall_cnt, 1);
        chk("t4_no_other", valid_cnt + par_cnt + ovr_cnt, 0);

        // back-to-back 0x11, 0x22 with ready low
        ready_i = 1'b0;
        epoch++;
        send_frame(7'h11, 1'b0, 1'b1, k);
        send_frame(7'h22, 1'b0, 1'b1, k2);
        wait_cyc(10);
        $display("frames 0x11,0x22: word=0x%02h valid=%0d overruns=%0d at +%0d", word_o, valid_o, ovr_cnt, ovr_cyc - k2);
        chk("t5_back2back", k2 - k, 10 * N);
        chk("t5_word", int'(word_o), 'h11);
        chk("t5_valid_held", int'(valid_o), 1);
        chk("t5_ovr_cnt", ovr_cnt, 1);
        chk("t5_ovr_time", ovr_cyc - k2, LAT);
        ready_i = 1'b1;
        wait_cyc(1);
        chk("t5_valid_fall", int'(valid_o), 0);

        // reset during data bit 3
        epoch++;
        k = cyc;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx_i = 1'b0;
        wait_cyc(8);
        chk("t6_busy_before", int'(busy_o), 1);
        srst = 1'b1;
        wait_cyc(1);
        srst = 1'b0;
        rx_i = 1'b1;
        $display("mid-frame reset: word=%0d valid=%0d busy=%0d", word_o, valid_o, busy_o);
        chk("t6_rst_word", int'(word_o), 0);
        chk("t6_rst_busy", int'(busy_o), 0);
        chk("t6_rst_valid", int'(valid_o), 0);
        wait_cyc(20);
        epoch++;
        send_frame(7'h05, 1'b0, 1'b1, k);
        wait_cyc(20);
        $display("frame 0x05: valid at +%0d, word=0x%02h", valid_cyc - k, valid_word);
        chk("t6_latency", valid_cyc - k, LAT);
        chk("t6_word", valid_word, 'h05);
        chk("t6_errs", par_cnt + frm_cnt + ovr_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
